// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// load_store_unit_if : request/response and data-memory bus of the LSU
// Revision: 1.0
// ============================================================================
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : RV32I byte-addressed loads/stores onto word-indexed memory
// Revision: 1.0
// ============================================================================
module load_store_unit #(
  parameter int DEPTH = 64
) (
  input  wire logic          clk,
  input  wire logic          reset,
  load_store_unit_if.slave   bus
);

  localparam logic [31:0] c_depth = 32'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    ERR    = 3'd5,
    RESP   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] resp_data_q;

  logic        accept;
  logic        bad_funct3;
  logic        misaligned;
  logic        out_of_range;
  logic        req_bad;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] merged;

  assign accept = (state_q == IDLE) && bus.req_valid;

  // Request checks are evaluated on the live request so ERR can answer at A+1.
  always_comb begin
    bad_funct3   = 1'b0;
    misaligned   = 1'b0;
    out_of_range = ({2'b00, bus.req_addr[31:2]} >= c_depth);
    if (bus.req_store)
      bad_funct3 = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      bad_funct3 = (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
    if (bus.req_funct3[1:0] == 2'b01)
      misaligned = bus.req_addr[0];
    else if (bus.req_funct3[1:0] == 2'b10)
      misaligned = (bus.req_addr[1:0] != 2'b00);
    req_bad = bad_funct3 || misaligned || out_of_range;
  end

  always_comb begin
    ld_value = 32'h0;
    ld_half  = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (addr_q[1:0])
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_value = bus.mem_rdata;
      3'b100:  ld_value = {24'h0, ld_byte};
      3'b101:  ld_value = {16'h0, ld_half};
      default: ld_value = 32'h0;
    endcase
  end

  always_comb begin
    merged = bus.mem_rdata;
    if (funct3_q[0])
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      merge_q     <= 32'h0;
      resp_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        if (req_bad)
          resp_data_q <= 32'h0;
      end
      case (state_q)
        LOAD:          resp_data_q <= ld_value;
        RMW_RD:        merge_q     <= merged;
        WRITE, RMW_WR: resp_data_q <= 32'h0;
        default:       ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_wdata  = 32'h0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_bad)
            state_d = ERR;
          else if (!bus.req_store)
            state_d = LOAD;
          else if (bus.req_funct3 == 3'b010)
            state_d = WRITE;
          else
            state_d = RMW_RD;
        end
      end
      LOAD: begin
        bus.mem_read = 1'b1;
        state_d      = RESP;
      end
      WRITE: begin
        bus.mem_write = 1'b1;
        bus.mem_wdata = wdata_q;
        state_d       = RESP;
      end
      RMW_RD: begin
        bus.mem_read = 1'b1;
        state_d      = RMW_WR;
      end
      RMW_WR: begin
        bus.mem_write = 1'b1;
        bus.mem_wdata = merge_q;
        state_d       = RESP;
      end
      ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
        state_d        = IDLE;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.resp_data = resp_data_q;
  assign bus.mem_addr  = {2'b00, addr_q[31:2]};

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : directed self-checking bench for load_store_unit
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  int          checks;
  int          errors;
  logic [31:0] mem [0:63];

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;
  int          r_rd;
  int          r_wr;

  load_store_unit_if lsu_bus ();

  load_store_unit #(.DEPTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lsu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign lsu_bus.mem_rdata = mem[lsu_bus.mem_addr[5:0]];

  always @(posedge clk) begin
    if (lsu_bus.mem_write)
      mem[lsu_bus.mem_addr[5:0]] <= lsu_bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and records which cycles after accept saw mem_read,
  // mem_write and resp_valid (bit k of the masks = cycle A+k).
  task automatic run_req(input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    r_data = 32'hDEAD_BEEF;
    r_err  = 1'bx;
    r_lat  = 0;
    r_rd   = 0;
    r_wr   = 0;
    @(posedge clk); #1;
    lsu_bus.req_valid  = 1'b1;
    lsu_bus.req_store  = st;
    lsu_bus.req_funct3 = f3;
    lsu_bus.req_addr   = addr;
    lsu_bus.req_wdata  = wd;
    @(negedge clk);
    chk("req_ready_at_accept", {31'h0, lsu_bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    lsu_bus.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (lsu_bus.mem_read)  r_rd |= (1 << k);
      if (lsu_bus.mem_write) r_wr |= (1 << k);
      if (lsu_bus.mem_read || lsu_bus.mem_write)
        chk("mem_addr_stable", lsu_bus.mem_addr, {2'b00, addr[31:2]});
      if (lsu_bus.resp_valid) begin
        r_lat  = k;
        r_data = lsu_bus.resp_data;
        r_err  = lsu_bus.resp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    lsu_bus.req_valid  = 1'b0;
    lsu_bus.req_store  = 1'b0;
    lsu_bus.req_funct3 = 3'b000;
    lsu_bus.req_addr   = 32'h0;
    lsu_bus.req_wdata  = 32'h0;
    reset = 1'b1;
    #1;
    mem[3] <= 32'h8899_AABB;
    mem[2] <= 32'h1122_3344;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_req_ready",  {31'h0, lsu_bus.req_ready},  32'h1);
    chk("rst_resp_valid", {31'h0, lsu_bus.resp_valid}, 32'h0);
    chk("rst_resp_err",   {31'h0, lsu_bus.resp_err},   32'h0);
    chk("rst_mem_rw",     {30'h0, lsu_bus.mem_read, lsu_bus.mem_write}, 32'h0);
    chk("rst_resp_data",  lsu_bus.resp_data, 32'h0);
    chk("rst_mem_addr",   lsu_bus.mem_addr,  32'h0);
    chk("rst_mem_wdata",  lsu_bus.mem_wdata, 32'h0);

    // Loads from mem[3] = 0x8899AABB
    run_req(1'b0, 3'b000, 32'h0D, 32'h0);
    chk("lb_data", r_data, 32'hFFFF_FFAA);
    chk("lb_err",  {31'h0, r_err}, 32'h0);
    chk("lb_lat",  r_lat, 2);
    chk("lb_rd",   r_rd, 32'h2);
    chk("lb_wr",   r_wr, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_data_hold", lsu_bus.resp_data, 32'hFFFF_FFAA);

    run_req(1'b0, 3'b101, 32'h0E, 32'h0);
    chk("lhu_data", r_data, 32'h0000_8899);
    chk("lhu_lat",  r_lat, 2);
    run_req(1'b0, 3'b010, 32'h0C, 32'h0);
    chk("lw_data", r_data, 32'h8899_AABB);
    run_req(1'b0, 3'b001, 32'h0E, 32'h0);
    chk("lh_data", r_data, 32'hFFFF_8899);
    run_req(1'b0, 3'b100, 32'h0F, 32'h0);
    chk("lbu_data", r_data, 32'h0000_0088);

    // Sub-word stores into mem[2] = 0x11223344
    run_req(1'b1, 3'b000, 32'h09, 32'h1234_56FF);
    chk("sb_lat",  r_lat, 3);
    chk("sb_rd",   r_rd, 32'h2);
    chk("sb_wr",   r_wr, 32'h4);
    chk("sb_data", r_data, 32'h0);
    chk("sb_err",  {31'h0, r_err}, 32'h0);
    chk("sb_mem",  mem[2], 32'h1122_FF44);
    run_req(1'b1, 3'b001, 32'h0A, 32'h0000_BEEF);
    chk("sh_lat", r_lat, 3);
    chk("sh_mem", mem[2], 32'hBEEF_FF44);

    // Rejected requests: one-cycle error response, no memory traffic
    run_req(1'b0, 3'b010, 32'h06, 32'h0);
    chk("err_lw_mis", {r_lat[7:0], 23'h0, r_err}, {8'd1, 23'h0, 1'b1});
    chk("err_lw_mis_mem", r_rd | r_wr, 32'h0);
    run_req(1'b1, 3'b001, 32'h03, 32'h0);
    chk("err_sh_mis", {r_lat[7:0], 23'h0, r_err}, {8'd1, 23'h0, 1'b1});
    chk("err_sh_mis_mem", r_rd | r_wr, 32'h0);
    run_req(1'b1, 3'b010, 32'h100, 32'h5555_5555);
    chk("err_sw_range", {r_lat[7:0], 23'h0, r_err}, {8'd1, 23'h0, 1'b1});
    chk("err_sw_range_mem", r_rd | r_wr, 32'h0);
    chk("err_sw_range_data", r_data, 32'h0);
    run_req(1'b0, 3'b011, 32'h0, 32'h0);
    chk("err_f3", {r_lat[7:0], 23'h0, r_err}, {8'd1, 23'h0, 1'b1});
    chk("err_f3_mem", r_rd | r_wr, 32'h0);
    run_req(1'b1, 3'b100, 32'h08, 32'h0);
    chk("err_store_f3", {r_lat[7:0], 23'h0, r_err}, {8'd1, 23'h0, 1'b1});

    // Reset during RMW_RD aborts the store
    @(posedge clk); #1;
    lsu_bus.req_valid  = 1'b1;
    lsu_bus.req_store  = 1'b1;
    lsu_bus.req_funct3 = 3'b000;
    lsu_bus.req_addr   = 32'h08;
    lsu_bus.req_wdata  = 32'h55;
    @(posedge clk); #1;
    lsu_bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rd", {31'h0, lsu_bus.mem_read}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_wr",   {31'h0, lsu_bus.mem_write},  32'h0);
    chk("abort_no_resp", {31'h0, lsu_bus.resp_valid}, 32'h0);
    chk("abort_ready",   {31'h0, lsu_bus.req_ready},  32'h1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_quiet", {30'h0, lsu_bus.resp_valid, lsu_bus.mem_write}, 32'h0);
    end
    chk("abort_mem", mem[2], 32'hBEEF_FF44);

    // Back-to-back: SW then a held LW to the same word
    @(posedge clk); #1;
    lsu_bus.req_valid  = 1'b1;
    lsu_bus.req_store  = 1'b1;
    lsu_bus.req_funct3 = 3'b010;
    lsu_bus.req_addr   = 32'h10;
    lsu_bus.req_wdata  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    lsu_bus.req_store = 1'b0;
    lsu_bus.req_wdata = 32'h0;
    @(negedge clk);
    chk("b2b_sw_wr",    {31'h0, lsu_bus.mem_write}, 32'h1);
    chk("b2b_busy1",    {31'h0, lsu_bus.req_ready}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_sw_resp",  {30'h0, lsu_bus.resp_valid, lsu_bus.resp_err}, 32'h2);
    chk("b2b_busy2",    {31'h0, lsu_bus.req_ready}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_accept",   {31'h0, lsu_bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    lsu_bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_lw_rd",    {31'h0, lsu_bus.mem_read}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_lw_resp",  {30'h0, lsu_bus.resp_valid, lsu_bus.resp_err}, 32'h2);
    chk("b2b_lw_data",  lsu_bus.resp_data, 32'hCAFE_F00D);
    chk("b2b_mem",      mem[4], 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Read and write strobes must never overlap.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert (!(lsu_bus.mem_read && lsu_bus.mem_write)) else begin
        errors++;
        $error("FAIL rw_exclusive observed=%b%b expected=not 11",
               lsu_bus.mem_read, lsu_bus.mem_write);
      end
    end
  end

endmodule
`default_nettype wire
